// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the UART register block and the transmit sequencer.
// The master offers tx_data/tx_valid; the slave answers with tx_ready.
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, DATA_BITS LSB-first, optional even parity (UART_PARITY_EN), STOP_BITS stops.
// Accepts one byte only in IDLE (tx_ready), so the bus side stalls for the whole frame; line frozen while tick is low.
module uart_tx_ctrl #(
  parameter int OVERSAMPLING = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  uart_tx_ctrl_if.slave tx_if,
  output logic          tx,
  output logic          busy
);

  localparam int TW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t                 state_q,    state_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q,  bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]   shift_q,    shift_d;
  logic                   tx_q,       tx_d;
  logic                   busy_q,     busy_d;
  logic                   rdy_q,      rdy_d;
`ifdef UART_PARITY_EN
  logic                   parity_q,   parity_d;
`endif

  logic bit_end;

  // A bit period closes on the OVERSAMPLING-th tick counted since the last boundary.
  assign bit_end = tick && (tick_cnt_q == TICK_LAST) && (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    rdy_d      = rdy_q;
`ifdef UART_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != S_IDLE && tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_if.tx_valid && rdy_q) begin
          state_d    = S_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          rdy_d      = 1'b0;
          tick_cnt_d = '0;
          shift_d    = tx_if.tx_data;
`ifdef UART_PARITY_EN
          parity_d   = ^tx_if.tx_data;
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            state_d    = S_PARITY;
            tx_d       = parity_q;
`else
            state_d    = S_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shift_q[1];
          end
        end
      end

`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b1;
`ifdef UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
`ifdef UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx_if.tx_ready = rdy_q;
  assign tx             = tx_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level line model plus directed and randomized traffic.
module tb_uart_tx_ctrl;
  localparam int OS = 16;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB      = 1 + DB + PB + SB;
  localparam int RUN_EXP = 64 * (SB + 1 - PB) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic tick = 1'b0;
  logic tx;
  logic busy;

  uart_tx_ctrl_if #(.DATA_BITS(DB)) bus ();

  uart_tx_ctrl #(
    .OVERSAMPLING(OS),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .tx_if(bus.slave),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int tick_mode = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    case (tick_mode)
      0:       tick = ((cyc % 4) == 3);
      1:       tick = 1'b1;
      2:       tick = ($urandom_range(0, 2) == 0);
      default: tick = 1'b0;
    endcase
  end

  // Line model: a frame is NB levels, each OS ticks long, counted from the acceptance edge.
  bit            m_active = 1'b0;
  int            m_k      = 0;
  logic [DB-1:0] m_data   = '0;
  int            acc_cnt  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_k      = 0;
    end else if (!m_active) begin
      if (bus.tx_valid) begin
        m_active = 1'b1;
        m_k      = 0;
        m_data   = bus.tx_data;
        acc_cnt++;
      end
    end else if (tick) begin
      m_k++;
      if (m_k == NB * OS) m_active = 1'b0;
    end
  end

  function automatic logic exp_bit(input int k, input logic [DB-1:0] d);
    int idx;
    idx = k / OS;
    if (idx == 0) return 1'b0;
    if (idx <= DB) return d[idx-1];
    if (PB != 0 && idx == DB + 1) return ^d;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n || !m_active) begin
        chk("tx_idle",   tx,           1'b1);
        chk("rdy_idle",  bus.tx_ready, 1'b1);
        chk("busy_idle", busy,         1'b0);
      end else begin
        chk("tx_frame",   tx,           exp_bit(m_k, m_data));
        chk("rdy_frame",  bus.tx_ready, 1'b0);
        chk("busy_frame", busy,         1'b1);
      end
    end
  end

  // Receiver: samples the line at mid-bit and decodes each completed frame.
  logic [NB-1:0] d_bits     = '0;
  bit            d_prev_act = 1'b0;
  int            d_prev_k   = 0;
  logic [DB-1:0] last_dec   = '0;
  logic          last_par   = 1'b0;
  int            n_frames   = 0;
  logic [DB-1:0] dec_q[$];

  always @(negedge clk) begin
    if (m_active && m_k != d_prev_k && (m_k % OS) == OS / 2) d_bits[m_k / OS] = tx;
    if (d_prev_act && !m_active && m_k == NB * OS) begin
      chk("dec_start", d_bits[0], 1'b0);
      last_dec = d_bits[DB:1];
      chk("dec_data", last_dec, m_data);
`ifdef UART_PARITY_EN
      last_par = d_bits[DB+1];
      chk("dec_parity", last_par, ^m_data);
`endif
      for (int s = 0; s < SB; s++) chk("dec_stop", d_bits[1+DB+PB+s], 1'b1);
      dec_q.push_back(last_dec);
      n_frames++;
    end
    d_prev_act = m_active;
    d_prev_k   = m_k;
  end

  task automatic send(input logic [DB-1:0] d);
    int a0;
    a0 = acc_cnt;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (acc_cnt != a0) break;
    end
    chk("send_accepted", acc_cnt != a0, 1'b1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!m_active && bus.tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_completed", ok, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_k(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (m_active && m_k >= k) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reached_bit", ok, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, lat, a0, rdy_n, run;
    logic [DB-1:0] got;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx",   tx,           1'b1);
    chk("rst_rdy",  bus.tx_ready, 1'b1);
    chk("rst_busy", busy,         1'b0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle with ticks running: nothing may move.
    tick_mode = 0;
    repeat (1000) @(negedge clk);
    chk("idle_tx",       tx,      1'b1);
    chk("idle_no_frame", acc_cnt, 0);

    // 0x55 with a tick every 4 clocks.
    dec_q.delete();
    send(8'h55);
    c0 = cyc;
    wait_idle();
    lat = cyc - c0 - 1;
    chk_rng("latency_55", lat, NB * OS * 4 - 3, NB * OS * 4);
    got = (dec_q.size() > 0) ? dec_q[0] : 8'h00;
    chk("byte_55", got, 8'h55);

    // Back-to-back with tx_valid held.
    dec_q.delete();
    a0 = acc_cnt;
    send_hold: begin
      bus.tx_data  = 8'hA5;
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (acc_cnt != a0) break;
      end
      chk("b2b_first_accept", acc_cnt, a0 + 1);
      bus.tx_data = 8'h3C;
      rdy_n = 0;
      run   = 0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (acc_cnt == a0 + 2) break;
        if (bus.tx_ready) rdy_n++;
        run = tx ? run + 1 : 0;
      end
      chk("b2b_second_accept", acc_cnt, a0 + 2);
      bus.tx_valid = 1'b0;
    end
    chk("b2b_ready_cycles", rdy_n, 1);
    chk("b2b_high_run",     run,   RUN_EXP);
    wait_idle();
    chk("b2b_frames", dec_q.size(), 2);
    got = (dec_q.size() > 0) ? dec_q[0] : 8'h00;
    chk("byte_A5", got, 8'hA5);
    got = (dec_q.size() > 1) ? dec_q[1] : 8'h00;
    chk("byte_3C", got, 8'h3C);

    // Stall in the middle of data bit 2.
    dec_q.delete();
    send(8'h0F);
    wait_k(3 * OS + OS / 2);
    tick_mode = 3;
    repeat (500) @(negedge clk);
    chk("stall_tx",   tx,   1'b1);
    chk("stall_busy", busy, 1'b1);
    tick_mode = 0;
    wait_idle();
    got = (dec_q.size() > 0) ? dec_q[0] : 8'h00;
    chk("byte_0F", got, 8'h0F);

    // Reset during data bit 5 of 0xFF, then a clean frame.
    dec_q.delete();
    send(8'hFF);
    wait_k(6 * OS + 5);
    chk("pre_rst_tx", tx, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx",   tx,           1'b1);
    chk("midrst_rdy",  bus.tx_ready, 1'b1);
    chk("midrst_busy", busy,         1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("aborted_not_decoded", dec_q.size(), 0);
    send(8'h81);
    wait_idle();
    got = (dec_q.size() > 0) ? dec_q[0] : 8'h00;
    chk("byte_81", got, 8'h81);

`ifdef UART_PARITY_EN
    send(8'h07);
    wait_idle();
    chk("parity_07", last_par, 1'b1);
    send(8'h03);
    wait_idle();
    chk("parity_03", last_par, 1'b0);
`endif

    // Randomized traffic: varied tick rates, withdrawn requests, data changing after acceptance.
    a0 = n_frames;
    for (int seg = 0; seg < 12; seg++) begin
      tick_mode = $urandom_range(0, 2);
      repeat (500) begin
        @(negedge clk);
        if (!bus.tx_valid) begin
          if ($urandom_range(0, 5) == 0) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = DB'($urandom);
          end
        end else begin
          case ($urandom_range(0, 7))
            0:       bus.tx_valid = 1'b0;
            1:       bus.tx_data  = DB'($urandom);
            default: ;
          endcase
        end
      end
    end
    bus.tx_valid = 1'b0;
    tick_mode = 1;
    wait_idle();
    chk("random_frames_seen", n_frames > a0 + 4, 1'b1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit sequencer driven by the oversampling tick from the baud generator.
- Accepts parallel bytes over a valid/ready handshake.
- Counts OVERSAMPLING ticks per bit period and serialises start, data (LSB first) and stop bits onto the tx line.
- Sits between the bus-side UART register block and the pad.

Parameters:
OVERSAMPLING, 16, ticks per bit period (must match the baud generator setting); legal range ≥2
DATA_BITS, 8, data bits per frame; legal range 5..9
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-clk pulse at OVERSAMPLING × baud rate, from the baud generator
tx_data  input  DATA_BITS  byte to send, sampled on handshake
tx_valid  input  1  tx_data valid
tx_ready  output  1  controller can accept a byte
tx  output  1  serial line, idle high
busy  output  1  frame in progress

Behaviour:
- Reset values (asynchronous on rst_n low): tx=1, tx_ready=1, busy=0, state IDLE, all counters 0, shift register 0.
- Single clock domain; all outputs registered.
- Handshake: transfer occurs on a rising clk edge with tx_valid && tx_ready.
  - tx_ready is high only in IDLE.
  - tx_valid may be withdrawn before acceptance.
  - tx_data is latched into the shift register at transfer; later changes are ignored.
- States: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE:
  - tx=1, busy=0, tx ready=1; ticks ignored.
  - On transfer: next cycle state=START, tx=0, busy=1, tx_ready=0, tick_cnt=0.
- Tick counter tick_cnt, width clog2(OVERSAMPLING):
  - Increments only on clock cycles where tick=1.
  - A bit period ends on the tick where tick_cnt==OVERSAMPLING-1; tick_cnt then wraps to 0.
  - First bit period after acceptance lasts from acceptance to the OVERSAMPLING-th tick. The start bit may therefore exceed OVERSAMPLING ticks by less than one tick interval.
- START: at bit-period end → DATA, tx=shift[0], bit_cnt=0.
- DATA:
  - At each bit-period end: shift right and increment bit_cnt; tx=next LSB.
  - After bit_cnt==DATA_BITS-1 completes → STOP, tx=1, stop_cnt=0.
- STOP:
  - tx=1 for STOP_BITS bit periods.
  - At the final bit-period end → IDLE: tx_ready=1 and busy=0 on the following cycle.
- Back-to-back frames: if tx_valid is held, the next transfer happens in the first IDLE cycle. This gives exactly one clk of idle-high between the stop bit and the next start bit.
- tick held low: state machine freezes and tx holds its current value indefinitely.
- tick high on every cycle is legal; one bit period = OVERSAMPLING clk cycles.
- Reset mid-frame: tx returns to 1 immediately (asynchronous); the frame is aborted, no partial resume.
- Width rule: bit_cnt is clog2(DATA_BITS) bits wide and never exceeds DATA_BITS-1.

Optional Feature:
Macro: UART_PARITY_EN
- Defined:
  - PARITY state inserted between the last data bit and STOP, lasting one bit period.
  - tx = even parity: XOR of the DATA_BITS bits latched at transfer.
  - Frame length = (2+DATA_BITS+STOP_BITS) bit periods.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- After reset, tick every 4th cycle, no tx_valid: tx=1, tx_ready=1, busy=0 for 1000 cycles; no state change.
- Send 0x55 (OVERSAMPLING=16, DATA_BITS=8, STOP_BITS=1, tick every 4 cycles, parity off): tx sequence 0,1,0,1,0,1,0,1,0,1, each level lasting 16 ticks (64 clk; start bit ≤64+3 clk); tx_ready returns high 640±3 clk after acceptance.
- tx_valid held high with 0xA5 then 0x3C: both frames decode correctly LSB first; exactly one clk of tx=1 between stop bit of 0xA5 and start bit of 0x3C; tx_ready high for exactly one cycle between frames.
- Stall: start 0x0F, hold tick=0 for 500 cycles mid data bit 2 → tx and busy frozen; resume ticks → frame completes with correct bits.
- Assert rst_n low during DATA bit 5 of 0xFF → tx=1, busy=0, tx_ready=1 immediately; after release, a new frame 0x81 transmits correctly.
- UART_PARITY_EN defined, send 0x07 → parity bit 1; send 0x03 → parity bit 0. STOP_BITS=2 build: stop level high for 32 ticks before tx_ready reasserts.
